uart_rx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_fifo.sv | 67 ++++++
 rtl/uart_rx_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: entry layout, timeout FSM
// encodings and default timing constants.
package uart_pkg;

  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_BAUD_PERIOD = 434;  // 50 MHz / 115200

  // FIFO entry layout is {perr, ferr, data}.
  function automatic int entry_w(input int data_bits);
    return data_bits + 2;
  endfunction

  function automatic int perr_bit(input int data_bits);
    return data_bits + 1;
  endfunction

  function automatic int ferr_bit(input int data_bits);
    return data_bits;
  endfunction

  localparam int ENTRY_W  = entry_w(DEF_DATA_BITS);
  localparam int PERR_BIT = perr_bit(DEF_DATA_BITS);
  localparam int FERR_BIT = ferr_bit(DEF_DATA_BITS);

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_ARMED   = 2'd1,
    T_EXPIRED = 2'd2
  } tmo_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers, registered level and
// synchronous flush. Reports which push/pop requests were actually accepted.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     push_ok,
  output logic                     pop_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      level_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is legal only when a pop frees a slot the same cycle.
  assign push_ok = push && (!full || pop) && !flush;
  assign pop_ok  = pop && !empty && !flush;

  assign level   = level_q;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + ONE;
        2'b01:   level_q <= level_q - ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define
  // which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule : uart_rx_fifo

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: buffers received characters with error tags and
// generates overrun/threshold/timeout interrupts plus saturating statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int BAUD_PERIOD   = DEF_BAUD_PERIOD,
  parameter int TIMEOUT_CHARS = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_wr_en,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_parity_error,
  input  logic                          rx_framing_error,
  input  logic                          flush,
  input  logic [$clog2(FIFO_DEPTH):0]   thresh,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          irq_thresh,
  output logic                          irq_timeout,
  output logic                          irq_error,
  input  logic                          irq_clr,
  input  logic                          cnt_clr,
  output logic [ERR_CNT_W-1:0]          overrun_cnt,
  output logic [ERR_CNT_W-1:0]          parity_cnt,
  output logic [ERR_CNT_W-1:0]          framing_cnt
);

  localparam int EW    = entry_w(DATA_BITS);
  localparam int P_POS = perr_bit(DATA_BITS);
  localparam int F_POS = ferr_bit(DATA_BITS);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TICKS = TIMEOUT_CHARS * 10 * BAUD_PERIOD;
  localparam int TW    = $clog2(TICKS + 1);

  localparam logic [TW-1:0]        TC      = TW'(TICKS - 1);
  localparam logic [TW-1:0]        T_ONE   = TW'(1);
  localparam logic [LW-1:0]        L_ONE   = LW'(1);
  localparam logic [ERR_CNT_W-1:0] C_ONE   = ERR_CNT_W'(1);

  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic          push_ok;
  logic          pop_ok;
  logic          overrun;
  logic          perr_acc;
  logic          ferr_acc;
  logic          will_empty;

  tmo_state_e    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  assign wr_entry = {rx_parity_error, rx_framing_error, rx_data};

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (rx_wr_en),
    .pop     (rd_en),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  assign rd_data = rd_entry[DATA_BITS-1:0];
  assign rd_perr = rd_entry[P_POS];
  assign rd_ferr = rd_entry[F_POS];

  // Flush takes the character, so it never counts as an overrun.
  assign overrun  = rx_wr_en && full && !rd_en && !flush;
  assign perr_acc = push_ok && rx_parity_error;
  assign ferr_acc = push_ok && rx_framing_error;

  assign irq_thresh  = (thresh != '0) && (level >= thresh);
  assign irq_timeout = (state_q == T_EXPIRED);

  // -------------------------------------------------------------------------
  // Saturating statistics; a same-cycle clear beats the increment.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
      parity_cnt  <= '0;
      framing_cnt <= '0;
    end else if (cnt_clr) begin
      overrun_cnt <= '0;
      parity_cnt  <= '0;
      framing_cnt <= '0;
    end else begin
      if (overrun  && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + C_ONE;
      if (perr_acc && (parity_cnt  != '1)) parity_cnt  <= parity_cnt  + C_ONE;
      if (ferr_acc && (framing_cnt != '1)) framing_cnt <= framing_cnt + C_ONE;
    end
  end

  // Sticky error interrupt; a new event in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              irq_error <= 1'b0;
    else if (overrun || perr_acc || ferr_acc) irq_error <= 1'b1;
    else if (irq_clr)                        irq_error <= 1'b0;
  end

  // -------------------------------------------------------------------------
  // Character-timeout FSM
  // -------------------------------------------------------------------------
  // True when the FIFO will hold nothing after this cycle's accepted traffic.
  assign will_empty = !push_ok && ((level == '0) || ((level == L_ONE) && pop_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T_IDLE;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tcnt_d  = '0;
    unique case (state_q)
      T_IDLE: begin
        if (!flush && (level != '0) && !will_empty) state_d = T_ARMED;
      end
      T_ARMED: begin
        if (flush || will_empty) begin
          state_d = T_IDLE;
        end else if (push_ok || pop_ok) begin
          tcnt_d = '0;
        end else if (tcnt_q == TC) begin
          state_d = T_EXPIRED;
        end else begin
          tcnt_d = tcnt_q + T_ONE;
        end
      end
      T_EXPIRED: begin
        if (flush) begin
          state_d = T_IDLE;
        end else if (push_ok || pop_ok) begin
          state_d = will_empty ? T_IDLE : T_ARMED;
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (depth 4, 200-cycle timeout).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_wr_en, rx_parity_error, rx_framing_error;
  logic [7:0] rx_data;
  logic       flush, rd_en, irq_clr, cnt_clr;
  logic [2:0] thresh;
  logic [7:0] rd_data;
  logic       rd_perr, rd_ferr, empty, full;
  logic [2:0] level;
  logic       irq_thresh, irq_timeout, irq_error;
  logic [7:0] overrun_cnt, parity_cnt, framing_cnt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_ov;

  uart_rx_ctrl #(
    .DATA_BITS(8), .FIFO_DEPTH(4), .BAUD_PERIOD(10), .TIMEOUT_CHARS(2), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_wr_en(rx_wr_en), .rx_data(rx_data),
    .rx_parity_error(rx_parity_error), .rx_framing_error(rx_framing_error),
    .flush(flush), .thresh(thresh), .rd_en(rd_en), .rd_data(rd_data),
    .rd_perr(rd_perr), .rd_ferr(rd_ferr), .empty(empty), .full(full),
    .level(level), .irq_thresh(irq_thresh), .irq_timeout(irq_timeout),
    .irq_error(irq_error), .irq_clr(irq_clr), .cnt_clr(cnt_clr),
    .overrun_cnt(overrun_cnt), .parity_cnt(parity_cnt), .framing_cnt(framing_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f);
    rx_data = d; rx_parity_error = p; rx_framing_error = f; rx_wr_en = 1'b1;
    tick();
    rx_wr_en = 1'b0; rx_parity_error = 1'b0; rx_framing_error = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if ({full, level, irq_thresh, irq_timeout, irq_error} !== 7'd0) begin
      failures++; $display("FAIL reset_flags got=%0h exp=0", {full, level, irq_thresh, irq_timeout, irq_error}); end
    checks++; if ({overrun_cnt, parity_cnt, framing_cnt} !== 24'd0) begin
      failures++; $display("FAIL reset_counters got=%0h exp=0", {overrun_cnt, parity_cnt, framing_cnt}); end
  endtask

  task automatic test_fifo_order();
    logic [7:0] v [4];
    v[0] = 8'h55; v[1] = 8'hA3; v[2] = 8'h0F; v[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      push(v[i], 1'b0, 1'b0);
      checks++; if (level !== 3'(i + 1)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", level, i + 1); end
      checks++; if (full !== (i == 3)) begin failures++; $display("FAIL fill_full got=%0b exp=%0b", full, i == 3); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== v[i]) begin failures++; $display("FAIL order_data got=%0h exp=%0h", rd_data, v[i]); end
      pop();
      checks++; if (level !== 3'(3 - i)) begin failures++; $display("FAIL drain_level got=%0d exp=%0d", level, 3 - i); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    checks++; if ({overrun_cnt, parity_cnt, framing_cnt} !== 24'd0) begin
      failures++; $display("FAIL clean_counters got=%0h exp=0", {overrun_cnt, parity_cnt, framing_cnt}); end
  endtask

  task automatic test_overrun();
    logic [7:0] v [4];
    v[0] = 8'h02; v[1] = 8'h03; v[2] = 8'h04; v[3] = 8'h12;
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b0, 1'b0);
    push(8'h11, 1'b0, 1'b0);
    exp_ov = 8'd1;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovr_level got=%0d exp=4", level); end
    checks++; if (overrun_cnt !== exp_ov) begin failures++; $display("FAIL ovr_cnt got=%0d exp=%0d", overrun_cnt, exp_ov); end
    checks++; if (irq_error !== 1'b1) begin failures++; $display("FAIL ovr_irq got=%0b exp=1", irq_error); end
    checks++; if (rd_data !== 8'h01) begin failures++; $display("FAIL ovr_head got=%0h exp=01", rd_data); end
    rx_data = 8'h12; rx_wr_en = 1'b1; rd_en = 1'b1;
    tick();
    rx_wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL rdwr_full_level got=%0d exp=4", level); end
    checks++; if (overrun_cnt !== exp_ov) begin failures++; $display("FAIL rdwr_full_ovr got=%0d exp=%0d", overrun_cnt, exp_ov); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== v[i]) begin failures++; $display("FAIL ovr_drain got=%0h exp=%0h", rd_data, v[i]); end
      pop();
    end
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    checks++; if (irq_error !== 1'b0) begin failures++; $display("FAIL ovr_irq_clr got=%0b exp=0", irq_error); end
  endtask

  task automatic test_errors();
    push(8'h22, 1'b1, 1'b0);
    push(8'h33, 1'b0, 1'b1);
    checks++; if ({parity_cnt, framing_cnt} !== {8'd1, 8'd1}) begin
      failures++; $display("FAIL err_counts got=%0h exp=0101", {parity_cnt, framing_cnt}); end
    checks++; if ({rd_data, rd_perr, rd_ferr} !== {8'h22, 1'b1, 1'b0}) begin
      failures++; $display("FAIL err_head1 got=%0h exp=%0h", {rd_data, rd_perr, rd_ferr}, {8'h22, 2'b10}); end
    checks++; if (irq_error !== 1'b1) begin failures++; $display("FAIL err_irq got=%0b exp=1", irq_error); end
    irq_clr = 1'b1;
    push(8'h44, 1'b1, 1'b0);
    irq_clr = 1'b0;
    checks++; if (irq_error !== 1'b1) begin failures++; $display("FAIL set_beats_clr got=%0b exp=1", irq_error); end
    checks++; if (parity_cnt !== 8'd2) begin failures++; $display("FAIL err_pcnt2 got=%0d exp=2", parity_cnt); end
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    checks++; if (irq_error !== 1'b0) begin failures++; $display("FAIL err_irq_clr got=%0b exp=0", irq_error); end
    pop();
    checks++; if ({rd_data, rd_perr, rd_ferr} !== {8'h33, 1'b0, 1'b1}) begin
      failures++; $display("FAIL err_head2 got=%0h exp=%0h", {rd_data, rd_perr, rd_ferr}, {8'h33, 2'b01}); end
    pop(); pop();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL err_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_thresh();
    thresh = 3'd3;
    for (int i = 0; i < 3; i++) begin
      push(8'(8'h60 + i), 1'b0, 1'b0);
      checks++; if (irq_thresh !== (i == 2)) begin failures++; $display("FAIL thr_rise got=%0b exp=%0b", irq_thresh, i == 2); end
    end
    pop();
    checks++; if (irq_thresh !== 1'b0) begin failures++; $display("FAIL thr_fall got=%0b exp=0", irq_thresh); end
    thresh = 3'd0;
    push(8'h70, 1'b0, 1'b0);
    push(8'h71, 1'b0, 1'b0);
    checks++; if ({full, irq_thresh} !== 2'b10) begin failures++; $display("FAIL thr_disabled got=%0b exp=10", {full, irq_thresh}); end
    repeat (4) pop();
  endtask

  task automatic test_timeout();
    int rise;
    checks++; if (irq_timeout !== 1'b0) begin failures++; $display("FAIL tmo_pre got=%0b exp=0", irq_timeout); end
    push(8'h5A, 1'b0, 1'b0);
    rise = 0;
    for (int k = 1; k <= 400 && rise == 0; k++) begin
      tick();
      if (irq_timeout === 1'b1) rise = k;
    end
    checks++; if (rise !== 201) begin failures++; $display("FAIL tmo_latency got=%0d exp=201", rise); end
    pop();
    checks++; if ({empty, irq_timeout} !== 2'b10) begin failures++; $display("FAIL tmo_pop got=%0b exp=10", {empty, irq_timeout}); end
    repeat (250) tick();
    checks++; if (irq_timeout !== 1'b0) begin failures++; $display("FAIL tmo_idle got=%0b exp=0", irq_timeout); end
    push(8'h6B, 1'b0, 1'b0);
    repeat (149) tick();
    push(8'h6C, 1'b0, 1'b0);
    rise = 0;
    for (int k = 1; k <= 400 && rise == 0; k++) begin
      tick();
      if (irq_timeout === 1'b1) rise = k;
    end
    checks++; if (rise !== 200) begin failures++; $display("FAIL tmo_restart got=%0d exp=200", rise); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if ({level, irq_timeout} !== 4'd0) begin failures++; $display("FAIL tmo_flush got=%0h exp=0", {level, irq_timeout}); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push(8'(8'h80 + i), 1'b0, 1'b0);
    rx_data = 8'h77; rx_wr_en = 1'b1; flush = 1'b1;
    tick();
    rx_wr_en = 1'b0; flush = 1'b0;
    checks++; if ({level, empty} !== {3'd0, 1'b1}) begin failures++; $display("FAIL flush_state got=%0h exp=1", {level, empty}); end
    checks++; if (overrun_cnt !== exp_ov) begin failures++; $display("FAIL flush_ovr got=%0d exp=%0d", overrun_cnt, exp_ov); end
    repeat (4) push(8'h90, 1'b0, 1'b0);
    rx_wr_en = 1'b1; flush = 1'b1;
    tick();
    rx_wr_en = 1'b0; flush = 1'b0;
    checks++; if ({overrun_cnt, level} !== {exp_ov, 3'd0}) begin
      failures++; $display("FAIL flush_full got=%0h exp=%0h", {overrun_cnt, level}, {exp_ov, 3'd0}); end
  endtask

  task automatic test_counters();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    checks++; if ({overrun_cnt, parity_cnt, framing_cnt} !== 24'd0) begin
      failures++; $display("FAIL cnt_clr got=%0h exp=0", {overrun_cnt, parity_cnt, framing_cnt}); end
    repeat (4) push(8'hA0, 1'b0, 1'b0);
    rx_wr_en = 1'b1;
    repeat (300) tick();
    checks++; if (overrun_cnt !== 8'hFF) begin failures++; $display("FAIL cnt_saturate got=%0h exp=ff", overrun_cnt); end
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    rx_wr_en = 1'b0;
    checks++; if (overrun_cnt !== 8'd0) begin failures++; $display("FAIL cnt_clr_wins got=%0h exp=0", overrun_cnt); end
    flush = 1'b1; irq_clr = 1'b1; tick(); flush = 1'b0; irq_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    thresh = 3'd1;
    push(8'h81, 1'b1, 1'b0);
    push(8'h82, 1'b0, 1'b1);
    checks++; if ({level, parity_cnt, irq_thresh} !== {3'd2, 8'd1, 1'b1}) begin
      failures++; $display("FAIL ar_pre got=%0h exp=%0h", {level, parity_cnt, irq_thresh}, {3'd2, 8'd1, 1'b1}); end
    rx_data = 8'h83; rx_wr_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({level, empty, full, irq_error, irq_timeout} !== {3'd0, 1'b1, 3'b000}) begin
      failures++; $display("FAIL ar_flags got=%0h exp=%0h", {level, empty, full, irq_error, irq_timeout}, {3'd0, 4'b1000}); end
    checks++; if ({overrun_cnt, parity_cnt, framing_cnt, irq_thresh} !== 25'd0) begin
      failures++; $display("FAIL ar_counters got=%0h exp=0", {overrun_cnt, parity_cnt, framing_cnt, irq_thresh}); end
    rx_wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rx_wr_en = 1'b0; rx_data = '0; rx_parity_error = 1'b0;
    rx_framing_error = 1'b0; flush = 1'b0; thresh = '0; rd_en = 1'b0;
    irq_clr = 1'b0; cnt_clr = 1'b0; exp_ov = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_fifo_order();
    test_overrun();
    test_errors();
    test_thresh();
    test_timeout();
    test_flush();
    test_counters();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_ctrl
